// File: rtl/axi_rd_mux.sv
// N:1 AXI4 read-channel multiplexer: arbitrates AR requests, tags forwarded IDs with the master index, routes R beats back by tag.
// Optional macro AXI_RD_MUX_QOS_EN restricts arbitration to the eligible masters carrying the highest s_arqos.
module axi_rd_mux #(
    parameter int MST_N    = 4,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int IDW      = 4,
    parameter int MIW      = (MST_N > 1) ? $clog2(MST_N) : 1,
    parameter int MAX_OUTS = 4,
    parameter int ARB_MODE = 0
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [MST_N-1:0]              s_arvalid,
    output logic [MST_N-1:0]              s_arready,
    input  logic [MST_N-1:0][AW-1:0]      s_araddr,
    input  logic [MST_N-1:0][7:0]         s_arlen,
    input  logic [MST_N-1:0][2:0]         s_arsize,
    input  logic [MST_N-1:0][1:0]         s_arburst,
    input  logic [MST_N-1:0][IDW-1:0]     s_arid,
    input  logic [MST_N-1:0][3:0]         s_arqos,
    output logic [MST_N-1:0]              s_rvalid,
    input  logic [MST_N-1:0]              s_rready,
    output logic [MST_N-1:0][DW-1:0]      s_rdata,
    output logic [MST_N-1:0][1:0]         s_rresp,
    output logic [MST_N-1:0]              s_rlast,
    output logic [MST_N-1:0][IDW-1:0]     s_rid,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    output logic [AW-1:0]                 m_araddr,
    output logic [7:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    output logic [3:0]                    m_arqos,
    output logic [IDW+MIW-1:0]            m_arid,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    input  logic [DW-1:0]                 m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    input  logic [IDW+MIW-1:0]            m_rid
);

    localparam int CW = 4;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                   state_q, state_d;
    logic [MIW-1:0]           ptr_q, ptr_d;
    logic [MST_N-1:0][CW-1:0] outs_q, outs_d;
    logic [AW-1:0]            araddr_q, araddr_d;
    logic [7:0]               arlen_q, arlen_d;
    logic [2:0]               arsize_q, arsize_d;
    logic [1:0]               arburst_q, arburst_d;
    logic [3:0]               arqos_q, arqos_d;
    logic [IDW+MIW-1:0]       arid_q, arid_d;

    logic [MST_N-1:0] eligible, cand, incVec, decVec;
    logic [MIW-1:0]   winIdx, rotIdx, rSel;
    logic             winValid, rHit, rLastHs;

    always_comb begin
        for (int i = 0; i < MST_N; i++) begin
            eligible[i] = s_arvalid[i] && (outs_q[i] < CW'(MAX_OUTS));
        end
    end

`ifdef AXI_RD_MUX_QOS_EN
    logic [3:0] maxQos;

    always_comb begin
        maxQos = '0;
        for (int i = 0; i < MST_N; i++) begin
            if (eligible[i] && (s_arqos[i] > maxQos)) maxQos = s_arqos[i];
        end
        for (int i = 0; i < MST_N; i++) begin
            cand[i] = eligible[i] && (s_arqos[i] == maxQos);
        end
    end
`else
    assign cand = eligible;
`endif

    // Loops run from lowest to highest priority so the last hit is the winner.
    always_comb begin
        winValid = 1'b0;
        winIdx   = '0;
        rotIdx   = '0;
        if (ARB_MODE == 1) begin
            for (int i = MST_N - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    winValid = 1'b1;
                    winIdx   = MIW'(i);
                end
            end
        end else begin
            for (int k = MST_N; k >= 1; k--) begin
                rotIdx = MIW'((int'(ptr_q) + k) % MST_N);
                if (cand[rotIdx]) begin
                    winValid = 1'b1;
                    winIdx   = rotIdx;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        arqos_d   = arqos_q;
        arid_d    = arid_q;
        s_arready = '0;
        case (state_q)
            IDLE: begin
                if (winValid && !areset) begin
                    s_arready[winIdx] = 1'b1;
                    araddr_d  = s_araddr[winIdx];
                    arlen_d   = s_arlen[winIdx];
                    arsize_d  = s_arsize[winIdx];
                    arburst_d = s_arburst[winIdx];
                    arqos_d   = s_arqos[winIdx];
                    arid_d    = {winIdx, s_arid[winIdx]};
                    ptr_d     = winIdx;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (m_arready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Tags beyond MST_N-1 can only appear when MST_N is not a power of two; such beats are sunk.
    assign rSel = m_rid[IDW+MIW-1:IDW];
    assign rHit = (int'(rSel) < MST_N);

    always_comb begin
        s_rvalid = '0;
        m_rready = 1'b1;
        if (rHit) begin
            s_rvalid[rSel] = m_rvalid;
            m_rready       = s_rready[rSel];
        end
    end

    assign rLastHs = m_rvalid && m_rready && m_rlast && rHit;

    always_comb begin
        for (int i = 0; i < MST_N; i++) begin
            incVec[i] = s_arvalid[i] && s_arready[i];
            decVec[i] = rLastHs && (rSel == MIW'(i));
            outs_d[i] = outs_q[i];
            if (incVec[i] && !decVec[i] && (outs_q[i] < CW'(MAX_OUTS))) begin
                outs_d[i] = outs_q[i] + CW'(1);
            end else if (decVec[i] && !incVec[i] && (outs_q[i] != '0)) begin
                outs_d[i] = outs_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            ptr_q     <= MIW'(MST_N - 1);
            outs_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            arqos_q   <= '0;
            arid_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            outs_q    <= outs_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            arqos_q   <= arqos_d;
            arid_q    <= arid_d;
        end
    end

    assign m_arvalid = (state_q == SEND);
    assign m_araddr  = araddr_q;
    assign m_arlen   = arlen_q;
    assign m_arsize  = arsize_q;
    assign m_arburst = arburst_q;
    assign m_arqos   = arqos_q;
    assign m_arid    = arid_q;

    assign s_rdata = {MST_N{m_rdata}};
    assign s_rresp = {MST_N{m_rresp}};
    assign s_rlast = {MST_N{m_rlast}};
    assign s_rid   = {MST_N{m_rid[IDW-1:0]}};

endmodule

// File: doc/axi_rd_mux.md
Name: axi_rd_mux

Overview:
- N:1 AXI4 read-channel multiplexer: MST_N upstream masters share one downstream slave port.
- Building block for the per-slave read path of the next-generation interconnect.
- Arbitrates AR requests (round-robin or fixed priority), tags each forwarded ID with the master index, and routes R beats back by that tag.
- Enforces a per-master outstanding-transaction limit.

Parameters:
- MST_N, 4, number of upstream master ports (2..16).
- AW, 32, address width.
- DW, 32, data width.
- IDW, 4, upstream ID width.
- MIW, $clog2(MST_N) (min 1), master-index tag width; downstream ID width is IDW+MIW.
- MAX_OUTS, 4, maximum outstanding read bursts per master (1..15).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- s_arvalid  in  [MST_N]x1  upstream AR valid
- s_arready  out  [MST_N]x1  upstream AR ready
- s_araddr  in  [MST_N]xAW  address
- s_arlen  in  [MST_N]x8  burst length
- s_arsize  in  [MST_N]x3  beat size
- s_arburst  in  [MST_N]x2  burst type
- s_arid  in  [MST_N]xIDW  ID
- s_arqos  in  [MST_N]x4  QoS
- s_rvalid  out  [MST_N]x1  R valid
- s_rready  in  [MST_N]x1  R ready
- s_rdata  out  [MST_N]xDW  R data (broadcast)
- s_rresp  out  [MST_N]x2  R response (broadcast)
- s_rlast  out  [MST_N]x1  R last (broadcast)
- s_rid  out  [MST_N]xIDW  low IDW bits of m_rid
- m_arvalid  out  1  downstream AR valid
- m_arready  in  1  downstream AR ready
- m_araddr/m_arlen/m_arsize/m_arburst/m_arqos  out  AW/8/3/2/4  latched winner payload
- m_arid  out  IDW+MIW  {winner index, s_arid}
- m_rvalid  in  1; m_rready  out  1; m_rdata  in  DW; m_rresp  in  2; m_rlast  in  1; m_rid  in  IDW+MIW

Behaviour:
- Clock aclk; reset areset is synchronous and active-high.
- Reset:
  - state IDLE; s_arready=0; m_arvalid=0; all payload registers 0.
  - Outstanding counters 0; RR pointer = MST_N-1, so master 0 has priority first.
  - Reset mid-burst abandons all in-flight state; no response recovery.
- Eligibility: master i is eligible when s_arvalid[i]=1 and outs[i] < MAX_OUTS.
- FSM IDLE:
  - If any master is eligible, pick a winner w: RR searches from ptr+1 upward with wrap; fixed priority takes the lowest eligible index.
  - In that same cycle, s_arready[w]=1 combinationally; all others stay 0.
  - Latch the payload and m_arid={w,s_arid[w]}; update ptr=w; go to SEND.
- FSM SEND:
  - m_arvalid=1; payload held stable.
  - On m_arready, go to IDLE; throughput is 1 AR per 2 cycles minimum.
  - No s_arready is asserted while in SEND.
- R routing (combinational):
  - sel = m_rid[IDW+MIW-1:IDW].
  - s_rvalid[sel] = m_rvalid; m_rready = s_rready[sel].
  - If sel >= MST_N (non-power-of-2 MST_N): m_rready=1, the beat is dropped, and no s_rvalid is asserted.
- Outstanding counters, per master:
  - +1 on AR accept (s_arvalid&s_arready).
  - -1 on the routed R handshake with m_rlast=1.
  - Both in the same cycle leaves the count unchanged.
  - Never exceeds MAX_OUTS; an underflow attempt (rlast with count 0) saturates at 0.
- Ordering: no reordering is performed; the downstream port may interleave IDs and beats are routed per beat.

Optional Feature:
- Macro AXI_RD_MUX_QOS_EN.
- Defined: among eligible masters, only those with the maximum s_arqos compete; ties are resolved by ARB_MODE.
- Undefined: s_arqos is ignored for arbitration.
- m_arqos carries the winner's QoS in both cases.

Test Plan:
- Reset check: hold areset 3 cycles with all s_arvalid=1 -> s_arready=0 and m_arvalid=0 during reset; first grant after release goes to master 0.
- RR fairness: ARB_MODE=0, all 4 masters request continuously, m_arready=1 -> grant order 0,1,2,3,0 and m_arid[5:4] follows the same order.
- Fixed priority: ARB_MODE=1, masters 1 and 3 request -> master 1 is granted repeatedly; master 3 is granted only after master 1 drops s_arvalid.
- Outstanding limit: MAX_OUTS=2, master 2 issues 3 ARs with no R returned -> third held with s_arready[2]=0; one rlast beat for id {2,x} -> third is accepted within 2 cycles.
- R routing/backpressure: m_rid={1,4'hA}, s_rready[1]=0 for 3 cycles -> s_rvalid[1]=1 only, m_rready=0, s_rid[1]=4'hA; handshake completes when s_rready[1]=1.
- QoS (macro defined): master 0 qos=2, master 3 qos=7 request together -> master 3 granted and m_arqos=7.
